// File: rtl/attn_score_engine_if.sv
// Handshake bundle for one attention-score engine: start/config, Q and K
// element streams, and the score stream toward softmax.
interface attn_score_engine_if #(
    parameter int WIDTH = 16,
    parameter int D_H   = 64,
    parameter int N_MAX = 256
);
    localparam int ACC_W = 2*WIDTH + $clog2(D_H);
    localparam int NT_W  = $clog2(N_MAX+1);
    localparam int IDX_W = $clog2(N_MAX);

    logic                    init;
    logic [NT_W-1:0]         n_tokens;
    logic                    ready;
    logic                    q_valid;
    logic signed [WIDTH-1:0] q_data;
    logic                    k_valid;
    logic signed [WIDTH-1:0] k_data;
    logic                    k_ready;
    logic                    score_valid;
    logic signed [ACC_W-1:0] score_data;
    logic [IDX_W-1:0]        score_idx;
    logic                    score_ready;
    logic signed [ACC_W-1:0] max_score;
    logic                    done;

    modport slave (
        input  init, n_tokens, q_valid, q_data, k_valid, k_data, score_ready,
        output ready, k_ready, score_valid, score_data, score_idx, max_score, done
    );

    modport master (
        output init, n_tokens, q_valid, q_data, k_valid, k_data, score_ready,
        input  ready, k_ready, score_valid, score_data, score_idx, max_score, done
    );
endinterface

// File: rtl/attn_score_engine.sv
// Holds one query row and emits (Q.K_i) >>> SHIFT for each streamed key row,
// tracking the running maximum score for the softmax stage.
module attn_score_engine #(
    parameter int WIDTH = 16,
    parameter int D_H   = 64,
    parameter int N_MAX = 256,
    parameter int SHIFT = 3
) (
    input logic clk,
    input logic reset_n,
    attn_score_engine_if.slave bus
);
    localparam int ACC_W = 2*WIDTH + $clog2(D_H);
    localparam int NT_W  = $clog2(N_MAX+1);
    localparam int IDX_W = $clog2(N_MAX);
    localparam int CNT_W = $clog2(D_H);

    typedef enum logic [2:0] {IDLE, LOAD_Q, MAC, EMIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        elemCnt_q;
    logic [IDX_W-1:0]        tokIdx_q;
    logic [NT_W-1:0]         nTok_q;
    logic signed [ACC_W-1:0] acc_q;
    logic signed [ACC_W-1:0] scoreData_q;
    logic [IDX_W-1:0]        scoreIdx_q;
    logic signed [ACC_W-1:0] maxScore_q;
    logic signed [WIDTH-1:0] qMem_q [D_H];

    logic                      initAccept;
    logic                      lastElem;
    logic                      lastTok;
    logic signed [2*WIDTH-1:0] product;
    logic signed [ACC_W-1:0]   productExt;
    logic signed [ACC_W-1:0]   accSum;
    logic signed [ACC_W-1:0]   scoreNew;

    assign initAccept = bus.init && (bus.n_tokens != '0) && (bus.n_tokens <= NT_W'(N_MAX));
    assign lastElem   = (elemCnt_q == CNT_W'(D_H-1));
    assign lastTok    = (NT_W'(tokIdx_q) == (nTok_q - NT_W'(1)));
    assign product    = qMem_q[elemCnt_q] * bus.k_data;
    assign productExt = {{(ACC_W-2*WIDTH){product[2*WIDTH-1]}}, product};
    assign accSum     = acc_q + productExt;
    assign scoreNew   = accSum >>> SHIFT;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (initAccept)                 state_d = LOAD_Q;
            LOAD_Q:  if (bus.q_valid && lastElem)    state_d = MAC;
            MAC:     if (bus.k_valid && lastElem)    state_d = EMIT;
            EMIT:    if (bus.score_ready)            state_d = lastTok ? DONE : MAC;
            DONE:                                    state_d = IDLE;
            default:                                 state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ready       = 1'b0;
        bus.k_ready     = 1'b0;
        bus.score_valid = 1'b0;
        bus.done        = 1'b0;
        case (state_q)
            IDLE:    bus.ready       = 1'b1;
            MAC:     bus.k_ready     = 1'b1;
            EMIT:    bus.score_valid = 1'b1;
            DONE:    bus.done        = 1'b1;
            default: ;
        endcase
    end

    assign bus.score_data = scoreData_q;
    assign bus.score_idx  = scoreIdx_q;
    assign bus.max_score  = maxScore_q;

    // The accumulator is cleared on the final beat so the next row starts from zero.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nTok_q      <= '0;
            elemCnt_q   <= '0;
            tokIdx_q    <= '0;
            acc_q       <= '0;
            scoreData_q <= '0;
            scoreIdx_q  <= '0;
            maxScore_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (initAccept) begin
                    nTok_q    <= bus.n_tokens;
                    elemCnt_q <= '0;
                    tokIdx_q  <= '0;
                end
                LOAD_Q: if (bus.q_valid) begin
                    if (lastElem) begin
                        elemCnt_q <= '0;
                        acc_q     <= '0;
                    end else begin
                        elemCnt_q <= elemCnt_q + CNT_W'(1);
                    end
                end
                MAC: if (bus.k_valid) begin
                    if (lastElem) begin
                        elemCnt_q   <= '0;
                        acc_q       <= '0;
                        scoreData_q <= scoreNew;
                        scoreIdx_q  <= tokIdx_q;
                        if ((tokIdx_q == '0) || (scoreNew > maxScore_q))
                            maxScore_q <= scoreNew;
                    end else begin
                        elemCnt_q <= elemCnt_q + CNT_W'(1);
                        acc_q     <= accSum;
                    end
                end
                EMIT: if (bus.score_ready && !lastTok) tokIdx_q <= tokIdx_q + IDX_W'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOAD_Q && bus.q_valid) qMem_q[elemCnt_q] <= bus.q_data;
    end
endmodule

// File: tb/tb_attn_score_engine.sv
// Bench for attn_score_engine: two D_H=4 instances (SHIFT 0 and 2) share one
// stimulus stream against a score queue; a D_H=64 instance covers extreme operands.
module tb_attn_score_engine;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    logic               init;
    logic [3:0]         nTok;
    logic               qValid;
    logic signed [15:0] qData;
    logic               kValid;
    logic signed [15:0] kData;
    logic               scoreReady;

    attn_score_engine_if #(.WIDTH(16), .D_H(4),  .N_MAX(8))   ifA ();
    attn_score_engine_if #(.WIDTH(16), .D_H(4),  .N_MAX(8))   ifB ();
    attn_score_engine_if #(.WIDTH(16), .D_H(64), .N_MAX(256)) ifC ();

    assign ifA.init = init;       assign ifB.init = init;
    assign ifA.n_tokens = nTok;   assign ifB.n_tokens = nTok;
    assign ifA.q_valid = qValid;  assign ifB.q_valid = qValid;
    assign ifA.q_data = qData;    assign ifB.q_data = qData;
    assign ifA.k_valid = kValid;  assign ifB.k_valid = kValid;
    assign ifA.k_data = kData;    assign ifB.k_data = kData;
    assign ifA.score_ready = scoreReady;
    assign ifB.score_ready = scoreReady;

    attn_score_engine #(.WIDTH(16), .D_H(4), .N_MAX(8), .SHIFT(0))
        dutA (.clk(clk), .reset_n(reset_n), .bus(ifA));
    attn_score_engine #(.WIDTH(16), .D_H(4), .N_MAX(8), .SHIFT(2))
        dutB (.clk(clk), .reset_n(reset_n), .bus(ifB));
    attn_score_engine #(.WIDTH(16), .D_H(64), .N_MAX(256), .SHIFT(3))
        dutC (.clk(clk), .reset_n(reset_n), .bus(ifC));

    typedef struct {
        longint raw;
        int     idx;
    } exp_t;

    exp_t   sbQ[$];
    int     vectors = 0;
    int     miscompares = 0;
    int     qRow[4];
    int     kRow[4];
    longint expMax;

    function automatic longint dotRow();
        longint s = 0;
        for (int i = 0; i < 4; i++) s += longint'(qRow[i]) * longint'(kRow[i]);
        return s;
    endfunction

    // Scoreboard: every score handshake pops the oldest expected row result.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset_n === 1'b1 && ifA.score_valid === 1'b1 && scoreReady === 1'b1) begin
            vectors++;
            if (sbQ.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL unexpected_score got %0d with empty queue", ifA.score_data);
            end else begin
                e = sbQ.pop_front();
                if (longint'(ifA.score_data) !== e.raw) begin
                    miscompares++;
                    $display("[TB] FAIL scoreA got %0d want %0d", ifA.score_data, e.raw);
                end
                if (longint'(ifB.score_data) !== (e.raw >>> 2)) begin
                    miscompares++;
                    $display("[TB] FAIL scoreB got %0d want %0d", ifB.score_data, e.raw >>> 2);
                end
                if (ifA.score_idx !== 3'(e.idx) || ifB.score_valid !== 1'b1) begin
                    miscompares++;
                    $display("[TB] FAIL score_idx got %0d (B valid %b) want %0d", ifA.score_idx, ifB.score_valid, e.idx);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startQuery(input int n);
        init = 1'b1;
        nTok = 4'(n);
        tick();
        init = 1'b0;
    endtask

    task automatic loadQ();
        for (int i = 0; i < 4; i++) begin
            qValid = 1'b1;
            qData  = 16'(qRow[i]);
            tick();
        end
        qValid = 1'b0;
    endtask

    task automatic sendK(input int v);
        int cnt = 0;
        kValid = 1'b1;
        kData  = 16'(v);
        @(negedge clk);
        while (ifA.k_ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        if (cnt >= 50) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL k_handshake timeout got k_ready=%b want 1", ifA.k_ready);
        end
        tick();
        kValid = 1'b0;
    endtask

    task automatic pushRow(input int idx);
        longint raw = dotRow();
        sbQ.push_back('{raw, idx});
        if (idx == 0 || raw > expMax) expMax = raw;
    endtask

    task automatic sendRow(input int idx);
        pushRow(idx);
        for (int i = 0; i < 4; i++) sendK(kRow[i]);
    endtask

    task automatic waitDone(output bit seen);
        seen = 1'b0;
        for (int c = 0; c < 50 && !seen; c++) begin
            @(negedge clk);
            if (ifA.done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #2;
        vectors++;
        if (ifA.ready !== 1'b1 || ifA.k_ready !== 1'b0 || ifA.score_valid !== 1'b0 || ifA.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl got ready=%b k_ready=%b valid=%b done=%b want 1 0 0 0", ifA.ready, ifA.k_ready, ifA.score_valid, ifA.done);
        end
        vectors++;
        if (ifA.score_data !== '0 || ifA.score_idx !== '0 || ifA.max_score !== '0 || ifC.ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_data got data=%0d idx=%0d max=%0d readyC=%b want 0 0 0 1", ifA.score_data, ifA.score_idx, ifA.max_score, ifC.ready);
        end
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_single();
        bit seen;
        qRow = '{1, 2, 3, 4};
        kRow = '{1, 1, 1, 1};
        tick();
        startQuery(1);
        vectors++;
        if (ifA.ready !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL single_ready_fall got %b want 0", ifA.ready);
        end
        loadQ();
        sendRow(0);
        waitDone(seen);
        vectors++;
        if (seen !== 1'b1 || ifB.done !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_done got %b/%b want 1", seen, ifB.done);
        end
        vectors++;
        if (longint'(ifA.max_score) !== expMax || longint'(ifB.max_score) !== (expMax >>> 2)) begin
            miscompares++;
            $display("[TB] FAIL single_max got %0d/%0d want %0d/%0d", ifA.max_score, ifB.max_score, expMax, expMax >>> 2);
        end
        @(negedge clk);
        vectors++;
        if (ifA.done !== 1'b0 || ifA.ready !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL single_after_done got done=%b ready=%b want 0 1", ifA.done, ifA.ready);
        end
    endtask

    task automatic test_multi();
        bit seen;
        qRow = '{-3, 2, 0, 1};
        tick();
        startQuery(3);
        loadQ();
        kRow = '{1, 1, 1, 1};
        sendRow(0);
        kRow = '{-4, 0, 0, 0};
        pushRow(1);
        sendK(kRow[0]);
        sendK(kRow[1]);
        init = 1'b1;
        nTok = 4'd1;
        sendK(kRow[2]);
        init = 1'b0;
        sendK(kRow[3]);
        kRow = '{0, 0, 0, -8};
        sendRow(2);
        waitDone(seen);
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL multi_done got %b want 1", seen);
        end
        vectors++;
        if (longint'(ifA.max_score) !== expMax || longint'(ifB.max_score) !== (expMax >>> 2)) begin
            miscompares++;
            $display("[TB] FAIL multi_max got %0d/%0d want %0d/%0d", ifA.max_score, ifB.max_score, expMax, expMax >>> 2);
        end
    endtask

    task automatic test_backpressure();
        bit     seen;
        longint r1;
        qRow = '{-3, 2, 0, 1};
        tick();
        startQuery(3);
        loadQ();
        kRow = '{1, 1, 1, 1};
        sendRow(0);
        kRow = '{-4, 0, 0, 0};
        r1 = dotRow();
        pushRow(1);
        sendK(kRow[0]);
        scoreReady = 1'b0;
        for (int i = 1; i < 4; i++) sendK(kRow[i]);
        kValid = 1'b1;
        kData  = 16'sd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            vectors++;
            if (ifA.k_ready !== 1'b0 || ifA.score_valid !== 1'b1 || ifA.score_idx !== 3'd1 ||
                longint'(ifB.score_data) !== (r1 >>> 2)) begin
                miscompares++;
                $display("[TB] FAIL stall_hold got k_ready=%b valid=%b idx=%0d dataB=%0d want 0 1 1 %0d",
                         ifA.k_ready, ifA.score_valid, ifA.score_idx, ifB.score_data, r1 >>> 2);
            end
        end
        tick();
        scoreReady = 1'b1;
        kRow = '{5, 0, 0, -8};
        sendRow(2);
        waitDone(seen);
        vectors++;
        if (seen !== 1'b1 || longint'(ifA.max_score) !== expMax) begin
            miscompares++;
            $display("[TB] FAIL stall_done got done=%b max=%0d want 1 %0d", seen, ifA.max_score, expMax);
        end
    endtask

    task automatic test_illegal_init();
        int bad[2] = '{0, 9};
        for (int b = 0; b < 2; b++) begin
            tick();
            init = 1'b1;
            nTok = 4'(bad[b]);
            tick();
            init = 1'b0;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                vectors++;
                if (ifA.ready !== 1'b1 || ifA.k_ready !== 1'b0 || ifA.score_valid !== 1'b0) begin
                    miscompares++;
                    $display("[TB] FAIL illegal_init n=%0d got ready=%b k_ready=%b valid=%b want 1 0 0",
                             bad[b], ifA.ready, ifA.k_ready, ifA.score_valid);
                end
            end
        end
    endtask

    task automatic test_extreme();
        longint expC = (longint'(64) * longint'(-32768) * longint'(-32768)) >>> 3;
        bit     seen = 1'b0;
        int     cnt;
        tick();
        ifC.init     = 1'b1;
        ifC.n_tokens = 9'd1;
        tick();
        ifC.init = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ifC.q_valid = 1'b1;
            ifC.q_data  = -16'sd32768;
            tick();
        end
        ifC.q_valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            ifC.k_valid = 1'b1;
            ifC.k_data  = -16'sd32768;
            cnt = 0;
            @(negedge clk);
            while (ifC.k_ready !== 1'b1 && cnt < 50) begin
                @(negedge clk);
                cnt++;
            end
            tick();
        end
        ifC.k_valid = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            if (ifC.score_valid === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b1 || longint'(ifC.score_data) !== expC || ifC.score_idx !== 8'd0) begin
            miscompares++;
            $display("[TB] FAIL extreme_score got valid=%b data=%0d idx=%0d want 1 %0d 0", seen, ifC.score_data, ifC.score_idx, expC);
        end
        vectors++;
        if (longint'(ifC.max_score) !== expC) begin
            miscompares++;
            $display("[TB] FAIL extreme_max got %0d want %0d", ifC.max_score, expC);
        end
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clk);
            if (ifC.done === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL extreme_done got %b want 1", seen);
        end
    endtask

    task automatic test_reset_mid();
        qRow = '{1, 2, 3, 4};
        kRow = '{1, 1, 1, 1};
        tick();
        startQuery(2);
        loadQ();
        pushRow(0);
        sendK(kRow[0]);
        sendK(kRow[1]);
        reset_n = 1'b0;
        #1;
        vectors++;
        if (ifA.ready !== 1'b1 || ifA.k_ready !== 1'b0 || ifA.score_valid !== 1'b0 || ifA.done !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_ctrl got ready=%b k_ready=%b valid=%b done=%b want 1 0 0 0", ifA.ready, ifA.k_ready, ifA.score_valid, ifA.done);
        end
        vectors++;
        if (ifA.score_data !== '0 || ifA.score_idx !== '0 || ifA.max_score !== '0 || ifB.max_score !== '0) begin
            miscompares++;
            $display("[TB] FAIL midreset_data got data=%0d idx=%0d max=%0d/%0d want 0", ifA.score_data, ifA.score_idx, ifA.max_score, ifB.max_score);
        end
        sbQ.delete();
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got no finish want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        init = 1'b0; nTok = '0; qValid = 1'b0; qData = '0;
        kValid = 1'b0; kData = '0; scoreReady = 1'b1; expMax = 0;
        ifC.init = 1'b0; ifC.n_tokens = '0; ifC.q_valid = 1'b0; ifC.q_data = '0;
        ifC.k_valid = 1'b0; ifC.k_data = '0; ifC.score_ready = 1'b1;

        test_reset();
        test_single();
        test_multi();
        test_backpressure();
        test_illegal_init();
        test_extreme();
        test_reset_mid();
        test_single();

        vectors++;
        if (sbQ.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL leftover_scores got %0d pending want 0", sbQ.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
